led_target_game: RTL and testbench
==================================

# led_target_game

Parametrised target-and-score engine for the reaction game: lights one of N_LEDS targets on each `change` strobe, scores a hit when the matching button is pressed before a programmable timeout, and counts misses for timeouts and wrong presses. Runs a fixed number of rounds, then flags game over. It sits between the LFSR/rate-timer front end and the score display/GPIO LED drivers. It generalises the single-round three-LED scorer with channel count, score width, timeout, miss tracking, button edge detection and a game state machine.

## Interface
- N_LEDS, 4, number of target LEDs/buttons (2..16)
- SCORE_W, 8, width of score and miss counters
- TIMEOUT_W, 16, width of timeout counter
- ROUNDS, 16, targets presented per game (1..2^SCORE_W-1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  level; high runs a game, low aborts/returns to idle
- change  in  1  one-cycle strobe requesting a new target
- rand_num  in  $clog2(N_LEDS)  target index from LFSR
- btn  in  N_LEDS  synchronised, debounced buttons, active high
- timeout_cycles  in  TIMEOUT_W  cycles a target stays lit; 0 treated as 1
- led  out  N_LEDS  one-hot target, or all zero
- score  out  SCORE_W  hits, saturating
- misses  out  SCORE_W  timeouts plus wrong presses, saturating
- round_cnt  out  SCORE_W  targets presented this game
- game_over  out  1  high in DONE

## Operation
- States: IDLE, WAIT (no target), LIT (target shown), DONE.
- Reset (rst=0): state IDLE; led=0, score=0, misses=0, round_cnt=0, game_over=0, button history=0.
- Edge detect: press[i] = btn[i] & ~btn_q[i]; btn_q registered every cycle in all states. Only rising edges count; held buttons score once.
- IDLE: led=0. start=1 -> clear score, misses, round_cnt; go WAIT.
- WAIT: change=1 and rand_num<N_LEDS -> led=1<<rand_num, latch target, load timer with max(timeout_cycles,1), round_cnt+1, go LIT. rand_num>=N_LEDS: strobe ignored, stay WAIT. Presses in WAIT ignored.
- LIT, priority per cycle:
  1. any press on a non-target button -> misses+1 (even if target also pressed the same cycle)
  2. else press on target -> score+1
  3. else timer==1 -> misses+1 (timeout)
  4. else timer-1, stay LIT
- Cases 1-3 clear led; next state DONE if round_cnt==ROUNDS, else WAIT.
- change during LIT ignored; timer is not reloaded.
- score/misses saturate at 2^SCORE_W-1; no wrap.
- DONE: led=0, game_over=1, counters held. start=0 -> IDLE (counters held until next start).
- start=0 in WAIT or LIT: abort to IDLE next edge, led=0, counters held, no miss charged.

## Timing
- change sampled at edge k -> led valid after edge k (1-cycle latency).
- Target lit for exactly max(timeout_cycles,1) cycles if unanswered; miss counted on the edge ending the last lit cycle.
- btn first sampled high at edge k -> score/misses/led update visible after edge k.
- game_over asserts the cycle after the final round resolves.
- rst overrides everything, including mid-LIT.

## Structure
- Package `led_game_pkg`: state enum (IDLE, WAIT, LIT, DONE), localparam IDX_W = $clog2(N_LEDS), saturating-increment function.
- One sub-module: `btn_edge_detect` (N_LEDS-wide register plus rising-edge mask, sync active-low reset).
- Top holds FSM, timer, target latch and counters.

## Test plan
- N_LEDS=4, timeout=10: start, change with rand_num=2 -> led=0100 next cycle; btn[2] rises 3 cycles later -> score=1, led=0000, state WAIT.
- Unanswered target, timeout=5 -> led high exactly 5 cycles, then misses=1, score=0.
- btn[0] and btn[2] rise same cycle with target 2 -> misses=1, score unchanged; btn[2] held 20 cycles scores at most once.
- ROUNDS=3, three hits -> round_cnt=3, score=3, game_over=1, further change ignored; start low -> IDLE, restart clears counters.
- SCORE_W=2, ROUNDS=3 with 5 wrong presses is impossible, so use ROUNDS=3, SCORE_W=2 with 3 hits then rerun mid-game abort: start low in LIT -> led=0, IDLE, no miss.
- rst=0 asserted while LIT with score=2 -> all outputs zero next cycle; timeout_cycles=0 -> target lit exactly 1 cycle.

Source files
------------

// File: rtl/led_game_pkg.sv
// Shared types and helpers for the LED target game: game states, the
// default target-index width and a saturating counter increment.
package led_game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LIT,
        DONE
    } state_t;

    localparam int N_LEDS_DEFAULT = 4;
    localparam int IDX_W          = $clog2(N_LEDS_DEFAULT);

    // Adds one unless the value has already reached the limit.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registers the button vector every cycle and flags buttons that have just
// gone from released to pressed, so a held button produces one press pulse.
module btn_edge_detect #(
    parameter int N_LEDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_LEDS-1:0] btn,
    output logic [N_LEDS-1:0] press
);

    logic [N_LEDS-1:0] btn_q;

    // Button history, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/led_target_game.sv
// Target-and-score engine: lights one target per accepted change strobe,
// scores a rising press on the target, charges a miss for a wrong press or
// a timeout, and stops after ROUNDS targets with game_over raised.
module led_target_game
    import led_game_pkg::*;
#(
    parameter int N_LEDS    = 4,
    parameter int SCORE_W   = 8,
    parameter int TIMEOUT_W = 16,
    parameter int ROUNDS    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       change,
    input  logic [$clog2(N_LEDS)-1:0]  rand_num,
    input  logic [N_LEDS-1:0]          btn,
    input  logic [TIMEOUT_W-1:0]       timeout_cycles,
    output logic [N_LEDS-1:0]          led,
    output logic [SCORE_W-1:0]         score,
    output logic [SCORE_W-1:0]         misses,
    output logic [SCORE_W-1:0]         round_cnt,
    output logic                       game_over
);

    localparam int          TGT_W   = $clog2(N_LEDS);
    localparam logic [31:0] CNT_MAX = (32'd1 << SCORE_W) - 32'd1;

    state_t               state;
    state_t               next_state;
    logic [TGT_W-1:0]     target;
    logic [TIMEOUT_W-1:0] timer;
    logic [N_LEDS-1:0]    press;
    logic [N_LEDS-1:0]    target_mask;
    logic                 valid_pick;
    logic                 wrong_press;
    logic                 hit;
    logic                 expire;
    logic                 resolve;
    logic                 last_round;

    btn_edge_detect #(
        .N_LEDS(N_LEDS)
    ) u_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    // A wrong press outranks a simultaneous target press; a pending timeout
    // only counts when no press arrived in that cycle.
    assign target_mask = N_LEDS'(1) << target;
    assign valid_pick  = change && (32'(rand_num) < 32'(N_LEDS));
    assign wrong_press = |(press & ~target_mask);
    assign hit         = |(press & target_mask);
    assign expire      = (timer == TIMEOUT_W'(1));
    assign resolve     = wrong_press || hit || expire;
    assign last_round  = (round_cnt == SCORE_W'(ROUNDS));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping start aborts from any running state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = WAIT;
            WAIT: begin
                if (!start)          next_state = IDLE;
                else if (valid_pick) next_state = LIT;
            end
            LIT: begin
                if (!start)       next_state = IDLE;
                else if (resolve) next_state = last_round ? DONE : WAIT;
            end
            DONE: if (!start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded purely from the state and the latched target.
    always_comb begin
        led       = '0;
        game_over = 1'b0;
        case (state)
            LIT:     led       = target_mask;
            DONE:    game_over = 1'b1;
            default: ;
        endcase
    end

    // Target latch, lit-time countdown and the three game counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            target    <= '0;
            timer     <= '0;
            score     <= '0;
            misses    <= '0;
            round_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        score     <= '0;
                        misses    <= '0;
                        round_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (start && valid_pick) begin
                        target    <= rand_num;
                        timer     <= (timeout_cycles == '0) ? TIMEOUT_W'(1) : timeout_cycles;
                        round_cnt <= SCORE_W'(sat_inc(32'(round_cnt), CNT_MAX));
                    end
                end
                LIT: begin
                    if (start) begin
                        if (wrong_press || (!hit && expire)) begin
                            misses <= SCORE_W'(sat_inc(32'(misses), CNT_MAX));
                        end else if (hit) begin
                            score <= SCORE_W'(sat_inc(32'(score), CNT_MAX));
                        end else begin
                            timer <= timer - TIMEOUT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_target_game.sv
// Self-checking bench for led_target_game: directed scenarios followed by a
// long randomized run, all compared against a behavioural game model.
module tb_led_target_game;

    localparam int N_LEDS    = 5;
    localparam int SCORE_W   = 4;
    localparam int TIMEOUT_W = 8;
    localparam int ROUNDS    = 3;
    localparam int CNT_MAX   = (1 << SCORE_W) - 1;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 change;
    logic [2:0]           randNum;
    logic [N_LEDS-1:0]    btn;
    logic [TIMEOUT_W-1:0] timeoutCycles;
    logic [N_LEDS-1:0]    led;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   misses;
    logic [SCORE_W-1:0]   roundCnt;
    logic                 gameOver;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the game as a player would describe it.
    bit gameRunning;
    bit gameFinished;
    bit targetShown;
    int mTarget;
    int mLitLeft;
    int mScore;
    int mMisses;
    int mRounds;
    int prevBtn;

    led_target_game #(
        .N_LEDS   (N_LEDS),
        .SCORE_W  (SCORE_W),
        .TIMEOUT_W(TIMEOUT_W),
        .ROUNDS   (ROUNDS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .change        (change),
        .rand_num      (randNum),
        .btn           (btn),
        .timeout_cycles(timeoutCycles),
        .led           (led),
        .score         (score),
        .misses        (misses),
        .round_cnt     (roundCnt),
        .game_over     (gameOver)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advances the model by one clock using the inputs currently applied.
    task automatic modelStep();
        int rising;
        int targetBit;
        bit settled;
        if (!rst) begin
            gameRunning  = 0;
            gameFinished = 0;
            targetShown  = 0;
            mTarget      = 0;
            mLitLeft     = 0;
            mScore       = 0;
            mMisses      = 0;
            mRounds      = 0;
            prevBtn      = 0;
            return;
        end
        rising  = int'(btn) & ~prevBtn;
        prevBtn = int'(btn);
        if (gameFinished) begin
            if (!start) gameFinished = 0;
        end else if (!gameRunning) begin
            if (start) begin
                gameRunning = 1;
                mScore      = 0;
                mMisses     = 0;
                mRounds     = 0;
            end
        end else if (!start) begin
            gameRunning = 0;
            targetShown = 0;
        end else if (!targetShown) begin
            if (change && int'(randNum) < N_LEDS) begin
                targetShown = 1;
                mTarget     = int'(randNum);
                mLitLeft    = (timeoutCycles == 0) ? 1 : int'(timeoutCycles);
                mRounds     = mRounds + 1;
            end
        end else begin
            targetBit = 1 << mTarget;
            settled   = 1;
            if ((rising & ~targetBit) != 0)  mMisses = (mMisses < CNT_MAX) ? mMisses + 1 : mMisses;
            else if ((rising & targetBit) != 0) mScore = (mScore < CNT_MAX) ? mScore + 1 : mScore;
            else if (mLitLeft == 1)          mMisses = (mMisses < CNT_MAX) ? mMisses + 1 : mMisses;
            else begin
                mLitLeft = mLitLeft - 1;
                settled  = 0;
            end
            if (settled) begin
                targetShown = 0;
                if (mRounds == ROUNDS) begin
                    gameRunning  = 0;
                    gameFinished = 1;
                end
            end
        end
    endtask

    // One clock: update the model, take the edge, then settle before sampling.
    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit c, input int r, input int b);
        start   = s;
        change  = c;
        randNum = 3'(r);
        btn     = N_LEDS'(b);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);
        timeoutCycles = 8'd10;
        tick();
        tick();
        total++; if (led !== 5'b0)      begin bad++; $display("[TB] FAIL reset_led: got %b want %b", led, 5'b0); end
        total++; if (score !== 4'd0)    begin bad++; $display("[TB] FAIL reset_score: got %0d want 0", score); end
        total++; if (misses !== 4'd0)   begin bad++; $display("[TB] FAIL reset_misses: got %0d want 0", misses); end
        total++; if (roundCnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_round: got %0d want 0", roundCnt); end
        total++; if (gameOver !== 1'b0) begin bad++; $display("[TB] FAIL reset_game_over: got %b want 0", gameOver); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_hit();
        timeoutCycles = 8'd10;
        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 2, 0);
        tick();
        total++; if (led !== 5'b00100) begin bad++; $display("[TB] FAIL hit_led_on: got %b want %b", led, 5'b00100); end
        total++; if (roundCnt !== 4'd1) begin bad++; $display("[TB] FAIL hit_round: got %0d want 1", roundCnt); end
        applyStimulus(1, 0, 0, 0);
        tick();
        tick();
        applyStimulus(1, 0, 0, 5'b00100);
        tick();
        total++; if (score !== 4'd1)  begin bad++; $display("[TB] FAIL hit_score: got %0d want 1", score); end
        total++; if (led !== 5'b0)    begin bad++; $display("[TB] FAIL hit_led_off: got %b want %b", led, 5'b0); end
        total++; if (misses !== 4'd0) begin bad++; $display("[TB] FAIL hit_misses: got %0d want 0", misses); end
        applyStimulus(1, 0, 0, 0);
        tick();
    endtask

    task automatic test_timeout();
        int litCount;
        timeoutCycles = 8'd5;
        applyStimulus(1, 1, 1, 0);
        tick();
        litCount = (led == 5'b00010) ? 1 : 0;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (led == 5'b00010) litCount++;
        end
        total++; if (litCount != 5)   begin bad++; $display("[TB] FAIL timeout_lit_cycles: got %0d want 5", litCount); end
        total++; if (misses !== 4'd1) begin bad++; $display("[TB] FAIL timeout_misses: got %0d want 1", misses); end
        total++; if (score !== 4'd1)  begin bad++; $display("[TB] FAIL timeout_score: got %0d want 1", score); end
    endtask

    task automatic test_wrong_press();
        timeoutCycles = 8'd10;
        applyStimulus(1, 1, 2, 0);
        tick();
        applyStimulus(1, 0, 0, 5'b00101);
        tick();
        total++; if (misses !== 4'd2)   begin bad++; $display("[TB] FAIL wrong_misses: got %0d want 2", misses); end
        total++; if (score !== 4'd1)    begin bad++; $display("[TB] FAIL wrong_score: got %0d want 1", score); end
        total++; if (led !== 5'b0)      begin bad++; $display("[TB] FAIL wrong_led: got %b want %b", led, 5'b0); end
        total++; if (gameOver !== 1'b1) begin bad++; $display("[TB] FAIL wrong_game_over: got %b want 1", gameOver); end
        applyStimulus(1, 0, 0, 0);
        tick();
    endtask

    task automatic test_rounds_and_hold();
        applyStimulus(0, 0, 0, 0);
        tick();
        total++; if (gameOver !== 1'b0) begin bad++; $display("[TB] FAIL idle_game_over: got %b want 0", gameOver); end
        total++; if (score !== 4'd1)    begin bad++; $display("[TB] FAIL idle_score_held: got %0d want 1", score); end
        applyStimulus(1, 0, 0, 0);
        tick();
        total++; if (score !== 4'd0 || misses !== 4'd0 || roundCnt !== 4'd0) begin
            bad++; $display("[TB] FAIL restart_clear: got %0d/%0d/%0d want 0/0/0", score, misses, roundCnt);
        end
        applyStimulus(1, 1, 2, 0);
        tick();
        applyStimulus(1, 0, 0, 5'b00100);
        tick();
        for (int i = 0; i < 20; i++) tick();
        applyStimulus(1, 1, 2, 5'b00100);
        tick();
        applyStimulus(1, 0, 0, 5'b00100);
        tick();
        tick();
        tick();
        total++; if (score !== 4'd1)   begin bad++; $display("[TB] FAIL hold_score_once: got %0d want 1", score); end
        total++; if (led !== 5'b00100) begin bad++; $display("[TB] FAIL hold_led_lit: got %b want %b", led, 5'b00100); end
        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 5'b00100);
        tick();
        applyStimulus(1, 1, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 5'b00001);
        tick();
        total++; if (score !== 4'd3)    begin bad++; $display("[TB] FAIL rounds_score: got %0d want 3", score); end
        total++; if (roundCnt !== 4'd3) begin bad++; $display("[TB] FAIL rounds_count: got %0d want 3", roundCnt); end
        total++; if (gameOver !== 1'b1) begin bad++; $display("[TB] FAIL rounds_game_over: got %b want 1", gameOver); end
        applyStimulus(1, 1, 1, 0);
        tick();
        applyStimulus(1, 0, 0, 0);
        tick();
        total++; if (led !== 5'b0 || roundCnt !== 4'd3) begin
            bad++; $display("[TB] FAIL done_ignores_change: got led=%b round=%0d want 00000/3", led, roundCnt);
        end
    endtask

    task automatic test_abort();
        applyStimulus(0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 6, 0);
        tick();
        total++; if (led !== 5'b0 || roundCnt !== 4'd0) begin
            bad++; $display("[TB] FAIL out_of_range_pick: got led=%b round=%0d want 00000/0", led, roundCnt);
        end
        applyStimulus(1, 1, 3, 0);
        tick();
        total++; if (led !== 5'b01000) begin bad++; $display("[TB] FAIL abort_led_on: got %b want %b", led, 5'b01000); end
        applyStimulus(0, 0, 0, 0);
        tick();
        total++; if (led !== 5'b0 || misses !== 4'd0 || roundCnt !== 4'd1 || gameOver !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_state: got led=%b miss=%0d round=%0d over=%b want 00000/0/1/0",
                            led, misses, roundCnt, gameOver);
        end
    endtask

    task automatic test_reset_mid();
        timeoutCycles = 8'd10;
        applyStimulus(1, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 1, 0);
            tick();
            applyStimulus(1, 0, 0, 5'b00010);
            tick();
            applyStimulus(1, 0, 0, 0);
            tick();
        end
        applyStimulus(1, 1, 4, 0);
        tick();
        applyStimulus(1, 0, 0, 0);
        total++; if (led !== 5'b10000 || score !== 4'd2) begin
            bad++; $display("[TB] FAIL pre_reset_lit: got led=%b score=%0d want 10000/2", led, score);
        end
        rst = 1'b0;
        tick();
        total++; if (led !== 5'b0 || score !== 4'd0 || misses !== 4'd0 || roundCnt !== 4'd0 || gameOver !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_reset_clear: got led=%b s=%0d m=%0d r=%0d o=%b want all zero",
                            led, score, misses, roundCnt, gameOver);
        end
        rst = 1'b1;
        timeoutCycles = 8'd0;
        tick();
        applyStimulus(1, 1, 4, 0);
        tick();
        total++; if (led !== 5'b10000) begin bad++; $display("[TB] FAIL zero_timeout_lit: got %b want %b", led, 5'b10000); end
        applyStimulus(1, 0, 0, 0);
        tick();
        total++; if (led !== 5'b0 || misses !== 4'd1) begin
            bad++; $display("[TB] FAIL zero_timeout_miss: got led=%b miss=%0d want 00000/1", led, misses);
        end
    endtask

    task automatic test_random();
        int expLed;
        for (int i = 0; i < 800; i++) begin
            rst           = ($urandom_range(0, 149) != 0);
            start         = ($urandom_range(0, 24) != 0);
            change        = ($urandom_range(0, 3) == 0);
            randNum       = 3'($urandom_range(0, 7));
            timeoutCycles = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) btn = N_LEDS'($urandom_range(0, 31));
            tick();
            expLed = targetShown ? (1 << mTarget) : 0;
            total++; if (led !== N_LEDS'(expLed)) begin bad++; $display("[TB] FAIL rand_led @%0d: got %b want %b", i, led, N_LEDS'(expLed)); end
            total++; if (score !== SCORE_W'(mScore)) begin bad++; $display("[TB] FAIL rand_score @%0d: got %0d want %0d", i, score, mScore); end
            total++; if (misses !== SCORE_W'(mMisses)) begin bad++; $display("[TB] FAIL rand_misses @%0d: got %0d want %0d", i, misses, mMisses); end
            total++; if (roundCnt !== SCORE_W'(mRounds)) begin bad++; $display("[TB] FAIL rand_round @%0d: got %0d want %0d", i, roundCnt, mRounds); end
            total++; if (gameOver !== gameFinished) begin bad++; $display("[TB] FAIL rand_game_over @%0d: got %b want %b", i, gameOver, gameFinished); end
        end
    endtask

    // Directed scenarios in order, then the randomized run and the summary.
    initial begin
        rst           = 1'b0;
        timeoutCycles = 8'd10;
        applyStimulus(0, 0, 0, 0);
        test_reset();
        test_hit();
        test_timeout();
        test_wrong_press();
        test_rounds_and_hold();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
